jk_reg_bank: RTL and testbench

JK_REG_BANK -- requirements
Module: jk_reg_bank

---
 rtl/jk_reg_bank_if.sv | 26 ++
 rtl/jk_reg_bank.sv | 64 ++++++
 tb/tb_jk_reg_bank.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jk_reg_bank_if.sv
// Bus bundle for jk_reg_bank: control/data inputs from the master and the
// registered channel state returned by the bank.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
  logic             chg;

  // No valid/ready: every rising edge with en high is a transfer, en low holds.
  modport master (
    output en, mode, j, k, d,
    input  q, qbar, tc, chg
  );

  modport slave (
    input  en, mode, j, k, d,
    output q, qbar, tc, chg
  );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK channels that can also be parallel-loaded, counted as a
// binary word or shifted left, with terminal-count and change flags.
module jk_reg_bank #(
  parameter int             WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic          clk,
  input logic          rst,
  jk_reg_bank_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_SHIFT = 2'b11
  } mode_e;

  mode_e            mode;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             tc;
  logic             tc_next;
  logic             chg;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    q_next  = q;
    tc_next = 1'b0;
    case (mode)
      // set where j is high, keep where k is low; j&k high toggles
      MODE_JK:    q_next = (bus.j & ~q) | (~bus.k & q);
      MODE_LOAD:  q_next = bus.d;
      MODE_COUNT: begin
        q_next  = q + WIDTH'(1);
        tc_next = &q;
      end
      MODE_SHIFT: q_next = {q[WIDTH-2:0], bus.j[0]};
      default:    q_next = q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q   <= RST_VAL;
      tc  <= 1'b0;
      chg <= 1'b0;
    end else if (!bus.en) begin
      tc  <= 1'b0;
      chg <= 1'b0;
    end else begin
      q   <= q_next;
      tc  <= tc_next;
      chg <= (q_next != q);
    end
  end

  assign bus.q    = q;
  assign bus.qbar = ~q;
  assign bus.tc   = tc;
  assign bus.chg  = chg;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Bench for jk_reg_bank: directed scenarios plus randomized edges checked
// against a word-level reference model, on two instances (RST_VAL 0 and 1001).
module tb_jk_reg_bank;

  localparam int W = 4;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  jk_reg_bank_if #(.WIDTH(W)) bus_a ();
  jk_reg_bank_if #(.WIDTH(W)) bus_b ();

  jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b0000)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  jk_reg_bank #(.WIDTH(W), .RST_VAL(4'b1001)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state: index 0 = dut_a, 1 = dut_b
  int mq[2];
  int mtc[2];
  int mchg[2];
  int rst_val[2];

  logic       in_en;
  logic [1:0] in_mode;
  logic [3:0] in_j;
  logic [3:0] in_k;
  logic [3:0] in_d;

  // driver tasks
  task automatic drive(input logic en, input logic [1:0] mode,
                       input logic [3:0] j, input logic [3:0] k, input logic [3:0] d);
    in_en = en; in_mode = mode; in_j = j; in_k = k; in_d = d;
    bus_a.en = en; bus_a.mode = mode; bus_a.j = j; bus_a.k = k; bus_a.d = d;
    bus_b.en = en; bus_b.mode = mode; bus_b.j = j; bus_b.k = k; bus_b.d = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // word-level reference model of one edge
  task automatic model_edge(input int idx, input logic rst_n);
    int old_q;
    int nq;
    old_q = mq[idx];
    nq    = old_q;
    if (!rst_n) begin
      mq[idx] = rst_val[idx]; mtc[idx] = 0; mchg[idx] = 0;
    end else if (!in_en) begin
      mtc[idx] = 0; mchg[idx] = 0;
    end else begin
      case (in_mode)
        2'b00: begin
          nq = 0;
          for (int b = 0; b < W; b++) begin
            int ob;
            ob = (old_q >> b) & 1;
            if (in_j[b] && in_k[b])      nq += (1 - ob) << b;
            else if (in_j[b])            nq += 1 << b;
            else if (in_k[b])            nq += 0;
            else                         nq += ob << b;
          end
        end
        2'b01:   nq = int'(in_d);
        2'b10:   nq = (old_q + 1) % 16;
        default: nq = (old_q * 2 + int'(in_j[0])) % 16;
      endcase
      mtc[idx]  = (in_mode == 2'b10 && old_q == 15) ? 1 : 0;
      mchg[idx] = (nq != old_q) ? 1 : 0;
      mq[idx]   = nq;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0;
    drive(1'b1, 2'b01, 4'b1111, 4'b0000, 4'b1111);
    tick();
    checks += 5;
    if (bus_a.q !== 4'b0000) begin errors++; $display("FAIL reset_q_a got %b want 0000", bus_a.q); end
    if (bus_a.qbar !== 4'b1111) begin errors++; $display("FAIL reset_qbar_a got %b want 1111", bus_a.qbar); end
    if (bus_a.tc !== 1'b0 || bus_a.chg !== 1'b0) begin errors++; $display("FAIL reset_flags_a got tc=%b chg=%b want 0 0", bus_a.tc, bus_a.chg); end
    if (bus_b.q !== 4'b1001) begin errors++; $display("FAIL reset_q_b got %b want 1001", bus_b.q); end
    if (bus_b.tc !== 1'b0 || bus_b.chg !== 1'b0) begin errors++; $display("FAIL reset_flags_b got tc=%b chg=%b want 0 0", bus_b.tc, bus_b.chg); end
  endtask

  task automatic test_jk();
    logic [3:0] tj[4];
    logic [3:0] tk[4];
    logic [3:0] tq[4];
    logic       tchg[4];
    tj = '{4'b1010, 4'b0000, 4'b1111, 4'b0000};
    tk = '{4'b0000, 4'b0000, 4'b1111, 4'b1111};
    tq = '{4'b1010, 4'b1010, 4'b0101, 4'b0000};
    tchg = '{1'b1, 1'b0, 1'b1, 1'b1};
    rst_a = 1'b1; rst_b = 1'b1;
    for (int e = 0; e < 4; e++) begin
      drive(1'b1, 2'b00, tj[e], tk[e], 4'($urandom_range(0, 15)));
      tick();
      checks += 3;
      if (bus_a.q !== tq[e]) begin errors++; $display("FAIL jk_q edge%0d got %b want %b", e + 1, bus_a.q, tq[e]); end
      if (bus_a.chg !== tchg[e]) begin errors++; $display("FAIL jk_chg edge%0d got %b want %b", e + 1, bus_a.chg, tchg[e]); end
      if (bus_a.tc !== 1'b0) begin errors++; $display("FAIL jk_tc edge%0d got %b want 0", e + 1, bus_a.tc); end
    end
  endtask

  task automatic test_count_wrap();
    logic [3:0] tq[3];
    logic       ttc[3];
    tq  = '{4'b1111, 4'b0000, 4'b0001};
    ttc = '{1'b0, 1'b1, 1'b0};
    drive(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1110);
    tick();
    checks++;
    if (bus_a.q !== 4'b1110) begin errors++; $display("FAIL load_q got %b want 1110", bus_a.q); end
    for (int e = 0; e < 3; e++) begin
      drive(1'b1, 2'b10, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
      checks += 3;
      if (bus_a.q !== tq[e]) begin errors++; $display("FAIL count_q edge%0d got %b want %b", e + 1, bus_a.q, tq[e]); end
      if (bus_a.tc !== ttc[e]) begin errors++; $display("FAIL count_tc edge%0d got %b want %b", e + 1, bus_a.tc, ttc[e]); end
      if (bus_a.chg !== 1'b1) begin errors++; $display("FAIL count_chg edge%0d got %b want 1", e + 1, bus_a.chg); end
    end
  endtask

  task automatic test_shift();
    logic [3:0] tq[4];
    tq = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};
    drive(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0001);
    tick();
    for (int e = 0; e < 4; e++) begin
      logic [3:0] jv;
      jv = {3'($urandom_range(0, 7)), (e < 3) ? 1'b1 : 1'b0};
      drive(1'b1, 2'b11, jv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
      checks += 2;
      if (bus_a.q !== tq[e]) begin errors++; $display("FAIL shift_q edge%0d got %b want %b", e + 1, bus_a.q, tq[e]); end
      if (bus_a.qbar !== ~tq[e]) begin errors++; $display("FAIL shift_qbar edge%0d got %b want %b", e + 1, bus_a.qbar, ~tq[e]); end
    end
  endtask

  task automatic test_enable_hold();
    drive(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0101);
    tick();
    for (int e = 0; e < 5; e++) begin
      drive(1'b0, 2'b10, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
      checks += 2;
      if (bus_a.q !== 4'b0101) begin errors++; $display("FAIL hold_q edge%0d got %b want 0101", e + 1, bus_a.q); end
      if (bus_a.tc !== 1'b0 || bus_a.chg !== 1'b0) begin errors++; $display("FAIL hold_flags edge%0d got tc=%b chg=%b want 0 0", e + 1, bus_a.tc, bus_a.chg); end
    end
    drive(1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checks += 2;
    if (bus_a.q !== 4'b0110) begin errors++; $display("FAIL hold_release_q got %b want 0110", bus_a.q); end
    if (bus_a.chg !== 1'b1) begin errors++; $display("FAIL hold_release_chg got %b want 1", bus_a.chg); end
  endtask

  task automatic test_sync_reset();
    drive(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0111);
    tick();
    drive(1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000);
    #2 rst_b = 1'b0;
    #1;
    checks += 2;
    if (bus_b.q !== 4'b0111) begin errors++; $display("FAIL srst_between_edges_q got %b want 0111", bus_b.q); end
    if (bus_b.chg !== 1'b1) begin errors++; $display("FAIL srst_between_edges_chg got %b want 1", bus_b.chg); end
    tick();
    checks += 2;
    if (bus_b.q !== 4'b1001) begin errors++; $display("FAIL srst_q got %b want 1001", bus_b.q); end
    if (bus_b.tc !== 1'b0 || bus_b.chg !== 1'b0) begin errors++; $display("FAIL srst_flags got tc=%b chg=%b want 0 0", bus_b.tc, bus_b.chg); end
    drive(1'b0, 2'b01, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checks++;
    if (bus_b.q !== 4'b1001) begin errors++; $display("FAIL srst_override_q got %b want 1001", bus_b.q); end
    // reset at all-ones while counting: no terminal count may escape
    rst_b = 1'b1;
    drive(1'b1, 2'b01, 4'b0000, 4'b0000, 4'b1111);
    tick();
    rst_b = 1'b0;
    drive(1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0000);
    tick();
    checks += 2;
    if (bus_b.q !== 4'b1001) begin errors++; $display("FAIL srst_abort_q got %b want 1001", bus_b.q); end
    if (bus_b.tc !== 1'b0) begin errors++; $display("FAIL srst_abort_tc got %b want 0", bus_b.tc); end
    rst_b = 1'b1;
  endtask

  task automatic test_random();
    rst_a = 1'b0; rst_b = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000);
    model_edge(0, 1'b0);
    model_edge(1, 1'b0);
    tick();
    for (int n = 0; n < 200; n++) begin
      rst_a = ($urandom_range(0, 15) != 0);
      rst_b = ($urandom_range(0, 15) != 0);
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      model_edge(0, rst_a);
      model_edge(1, rst_b);
      tick();
      for (int idx = 0; idx < 2; idx++) begin
        logic [3:0] oq;
        logic [3:0] oqb;
        logic       otc;
        logic       ochg;
        oq   = (idx == 0) ? bus_a.q    : bus_b.q;
        oqb  = (idx == 0) ? bus_a.qbar : bus_b.qbar;
        otc  = (idx == 0) ? bus_a.tc   : bus_b.tc;
        ochg = (idx == 0) ? bus_a.chg  : bus_b.chg;
        checks += 5;
        if (oq !== 4'(mq[idx])) begin errors++; $display("FAIL rand_q n=%0d dut%0d got %b want %b", n, idx, oq, 4'(mq[idx])); end
        if (oqb !== ~4'(mq[idx])) begin errors++; $display("FAIL rand_qbar n=%0d dut%0d got %b want %b", n, idx, oqb, ~4'(mq[idx])); end
        if (oqb !== ~oq) begin errors++; $display("FAIL rand_qbar_inv n=%0d dut%0d got %b want %b", n, idx, oqb, ~oq); end
        if (otc !== 1'(mtc[idx])) begin errors++; $display("FAIL rand_tc n=%0d dut%0d got %b want %0d", n, idx, otc, mtc[idx]); end
        if (ochg !== 1'(mchg[idx])) begin errors++; $display("FAIL rand_chg n=%0d dut%0d got %b want %0d", n, idx, ochg, mchg[idx]); end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_val[0] = 0;
    rst_val[1] = 9;
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(1'b0, 2'b00, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    test_reset();
    test_jk();
    test_count_wrap();
    test_shift();
    test_enable_hold();
    test_sync_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
